// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    WAIT_REQ
  } state_t;

  localparam logic [15:0] TIMEOUT_DEF = 16'd50000;
  localparam int unsigned MAX_REQ     = 8;
  localparam int unsigned MAX_IW      = 3;

  // Index of the set bit in a one-hot vector; zero when nothing is set.
  function automatic logic [MAX_IW-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      if (oh[i]) r = MAX_IW'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin winner select: first request above ptr, wrapping around.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] sel;

  always_comb begin
    win = '0;
    sel = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      sel = IW'((int'(ptr) + k) % int'(NUM_REQ));
      if (win == '0 && req[sel]) win[sel] = 1'b1;
    end
    idx = IW'(onehot2idx(MAX_REQ'(win)));
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter feeding a single UART transmitter.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   last,
  input  logic [8*NUM_REQ-1:0] data,
  input  logic                 tx_done,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 err
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  state_t               state_q, state_n;
  logic [IW-1:0]        ptr_q, ptr_n, own_q, own_n, pick_idx;
  logic [NUM_REQ-1:0]   pick_oh, gnt_n, ack_n;
  logic [7:0]           tx_data_n;
  logic                 lst_q, lst_n, trmt_n, err_n, expire;
  logic [15:0]          wd_q, wd_n, wd_inc;
  logic [7:0]           bytes [NUM_REQ];

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_byte
    assign bytes[g] = data[8*g +: 8];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_oh),
    .idx (pick_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    own_n     = own_q;
    gnt_n     = gnt;
    tx_data_n = tx_data;
    lst_n     = lst_q;
    wd_n      = wd_q;
    trmt_n    = 1'b0;
    ack_n     = '0;
    err_n     = 1'b0;
    wd_inc    = (wd_q == TIMEOUT) ? wd_q : wd_q + 16'd1;
    expire    = (wd_inc == TIMEOUT - 16'd1);

    case (state_q)
      IDLE: begin
        if (|req) begin
          tx_data_n = bytes[pick_idx];
          lst_n     = last[pick_idx];
          gnt_n     = pick_oh;
          own_n     = pick_idx;
          trmt_n    = 1'b1;
          state_n   = SEND;
        end
      end
      SEND: begin
        wd_n    = '0;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_n = wd_inc;
        // tx_done takes precedence over a coincident watchdog expiry
        if (tx_done) begin
          ack_n = gnt;
          if (lst_q) begin
            gnt_n   = '0;
            ptr_n   = own_q;
            state_n = IDLE;
          end else begin
            state_n = WAIT_REQ;
          end
        end else if (expire) begin
          err_n   = 1'b1;
          gnt_n   = '0;
          ptr_n   = own_q;
          state_n = IDLE;
        end
      end
      WAIT_REQ: begin
        wd_n = wd_inc;
        if (req[own_q]) begin
          tx_data_n = bytes[own_q];
          lst_n     = last[own_q];
          trmt_n    = 1'b1;
          state_n   = SEND;
        end else if (expire) begin
          err_n   = 1'b1;
          gnt_n   = '0;
          ptr_n   = own_q;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      own_q   <= '0;
      gnt     <= '0;
      tx_data <= '0;
      lst_q   <= 1'b0;
      wd_q    <= '0;
      trmt    <= 1'b0;
      ack     <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      own_q   <= own_n;
      gnt     <= gnt_n;
      tx_data <= tx_data_n;
      lst_q   <= lst_n;
      wd_q    <= wd_n;
      trmt    <= trmt_n;
      ack     <= ack_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: per-cycle model compare plus directed scenarios.
module tb_uart_tx_arb;

  localparam int N  = 3;
  localparam int TO = 100;

  logic        clk, rst, tx_done, trmt, err;
  logic [2:0]  req, last, ack, gnt;
  logic [23:0] data;
  logic [7:0]  tx_data;

  uart_tx_arb #(.NUM_REQ(3), .TIMEOUT(16'd100)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .data(data), .tx_done(tx_done),
    .trmt(trmt), .tx_data(tx_data), .ack(ack), .gnt(gnt), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [2:0] v);
    case (v)
      3'b000:  return -1;
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -2;
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural model: owner, byte in flight, and cycles elapsed since the last start pulse.
  bit         m_ok = 0;
  int         m_own, m_ptr, m_since;
  bit         m_inflight, m_lastb;
  logic       m_trmt, m_err;
  logic [2:0] m_ack, m_gnt;
  logic [7:0] m_byte;

  task automatic m_take();
    m_byte     = 8'(data >> (8 * m_own));
    m_lastb    = last[2'(m_own)];
    m_trmt     = 1'b1;
    m_inflight = 1'b1;
    m_since    = 0;
  endtask

  task automatic m_release();
    m_ptr = m_own;
    m_own = -1;
    m_gnt = '0;
  endtask

  task automatic model_step();
    int cur;
    int w;
    m_trmt = 1'b0;
    m_ack  = '0;
    m_err  = 1'b0;
    if (rst) begin
      m_own = -1;
      m_ptr = N - 1;
      m_gnt = '0;
      m_ok  = 1;
    end else if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        w = (m_ptr + k) % N;
        if (m_own < 0 && req[2'(w)]) m_own = w;
      end
      if (m_own >= 0) begin
        m_take();
        m_gnt = 3'(1 << m_own);
      end
    end else begin
      cur     = m_since;
      m_since = cur + 1;
      if (cur != 0) begin
        if (m_inflight) begin
          if (tx_done) begin
            m_ack = m_gnt;
            if (m_lastb) m_release();
            else m_inflight = 1'b0;
          end else if (cur == TO - 1) begin
            m_err = 1'b1;
            m_release();
          end
        end else if (req[2'(m_own)]) begin
          m_take();
        end else if (cur == TO - 1) begin
          m_err = 1'b1;
          m_release();
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Event log used by the directed scenarios.
  int         n_tr, n_ak, n_er, er_cyc;
  int         tr_own [16], tr_cyc [16], ak_own [16], ak_cyc [16];
  logic [7:0] tr_dat [16];
  logic [2:0] ak_gnt [16], er_gnt;

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("trmt", trmt, m_trmt);
      chk("ack", ack, m_ack);
      chk("gnt", gnt, m_gnt);
      chk("err", err, m_err);
      if (m_gnt != 3'b000) chk("tx_data", tx_data, m_byte);
    end
    if (trmt === 1'b1 && n_tr < 16) begin
      tr_own[4'(n_tr)] = oh2i(gnt);
      tr_dat[4'(n_tr)] = tx_data;
      tr_cyc[4'(n_tr)] = cyc;
      n_tr++;
    end
    if (ack !== 3'b000 && n_ak < 16) begin
      ak_own[4'(n_ak)] = oh2i(ack);
      ak_gnt[4'(n_ak)] = gnt;
      ak_cyc[4'(n_ak)] = cyc;
      n_ak++;
    end
    if (err === 1'b1) begin
      n_er++;
      er_cyc = cyc;
      er_gnt = gnt;
    end
  end

  // Requesters: present queued bytes, advance on ack within the ack cycle.
  logic [8:0] fifo [3][16];
  int         hd [3], tl [3], rq_cyc [3];
  bit         act [3];
  logic [7:0] db [3];

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        act[2'(i)] = 0;
        hd[2'(i)]  = 0;
        tl[2'(i)]  = 0;
      end else begin
        if (act[2'(i)] && ack[2'(i)]) begin
          act[2'(i)] = 0;
          hd[2'(i)]++;
        end
        if (!act[2'(i)] && hd[2'(i)] != tl[2'(i)]) begin
          act[2'(i)]    = 1;
          rq_cyc[2'(i)] = cyc;
        end
      end
      req[2'(i)]  = act[2'(i)];
      last[2'(i)] = fifo[2'(i)][4'(hd[2'(i)])][8];
      db[2'(i)]   = fifo[2'(i)][4'(hd[2'(i)])][7:0];
    end
    data = {db[2], db[1], db[0]};
  end

  task automatic push(input int r, input logic [7:0] b, input logic l);
    fifo[2'(r)][4'(tl[2'(r)])] = {l, b};
    tl[2'(r)]++;
  endtask

  // UART stand-in: tx_done u_delay cycles after each trmt while enabled.
  int u_delay = 5;
  int u_cnt   = 0;
  bit u_en    = 1;
  bit inj     = 0;

  initial forever begin
    @(negedge clk);
    tx_done = 1'b0;
    if (rst) begin
      u_cnt = 0;
    end else begin
      if (u_cnt > 0) begin
        u_cnt--;
        if (u_cnt == 0) tx_done = 1'b1;
      end
      if (trmt === 1'b1 && u_en) u_cnt = u_delay;
    end
    if (inj) begin
      tx_done = 1'b1;
      inj     = 0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tr = 0;
    n_ak = 0;
    n_er = 0;
    rst  = 1'b0;
  endtask

  int e_own [4];
  int e_dat [4];
  int b;

  initial begin
    rst = 1'b1; req = '0; last = '0; data = '0; tx_done = 1'b0;
    n_tr = 0; n_ak = 0; n_er = 0;

    // Reset state
    do_reset();
    chk("rst_trmt", trmt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_err", err, 0);
    repeat (3) @(negedge clk);
    chk("idle_gnt", gnt, 0);

    // Single byte from requester 1
    do_reset();
    u_delay = 20;
    push(1, 8'h67, 1'b1);
    repeat (40) @(negedge clk);
    chk("a_ntrmt", n_tr, 1);
    chk("a_owner", tr_own[0], 1);
    chk("a_data", tr_dat[0], 8'h67);
    chk("a_latency", tr_cyc[0] - rq_cyc[1], 1);
    chk("a_nack", n_ak, 1);
    chk("a_ack_own", ak_own[0], 1);
    chk("a_ack_delay", ak_cyc[0] - tr_cyc[0], 21);
    chk("a_gnt_at_ack", ak_gnt[0], 0);

    // Fairness: 0,1,2,0
    do_reset();
    u_delay = 4;
    push(0, 8'h10, 1'b1);
    push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1);
    push(2, 8'h30, 1'b1);
    repeat (60) @(negedge clk);
    e_own = '{0, 1, 2, 0};
    e_dat = '{8'h10, 8'h20, 8'h30, 8'h11};
    chk("b_ntrmt", n_tr, 4);
    chk("b_nack", n_ak, 4);
    for (int j = 0; j < 4; j++) begin
      chk("b_owner", tr_own[j], e_own[j]);
      chk("b_data", tr_dat[j], e_dat[j]);
      chk("b_ack_own", ak_own[j], e_own[j]);
    end

    // Packet lock: requester 2 waits for the whole 3-byte packet
    do_reset();
    u_delay = 6;
    push(0, 8'hA5, 1'b0);
    push(0, 8'h5A, 1'b0);
    push(0, 8'h73, 1'b1);
    push(2, 8'h3C, 1'b1);
    repeat (60) @(negedge clk);
    e_own = '{0, 0, 0, 2};
    e_dat = '{8'hA5, 8'h5A, 8'h73, 8'h3C};
    chk("c_ntrmt", n_tr, 4);
    for (int j = 0; j < 4; j++) begin
      chk("c_owner", tr_own[j], e_own[j]);
      chk("c_data", tr_dat[j], e_dat[j]);
      chk("c_ack_own", ak_own[j], e_own[j]);
    end
    chk("c_next_byte_gap", tr_cyc[1] - ak_cyc[0], 1);
    chk("c_gnt_mid_pkt", ak_gnt[0], 3'b001);
    chk("c_gnt_end_pkt", ak_gnt[2], 0);
    chk("c_regrant_gap", tr_cyc[3] - ak_cyc[2], 1);

    // Timeout with no tx_done, then the next requester is served
    do_reset();
    u_en    = 0;
    u_delay = 5;
    push(1, 8'h44, 1'b1);
    push(2, 8'h55, 1'b1);
    b = 0;
    while (err !== 1'b1 && b < 150) begin
      @(negedge clk);
      b++;
    end
    chk("d_err_seen", err, 1);
    u_en = 1;
    repeat (30) @(negedge clk);
    chk("d_nerr", n_er, 1);
    chk("d_err_delay", er_cyc - tr_cyc[0], 100);
    chk("d_gnt_at_err", er_gnt, 0);
    chk("d_ntrmt", n_tr, 3);
    chk("d_first_owner", tr_own[0], 1);
    chk("d_next_owner", tr_own[1], 2);
    chk("d_next_data", tr_dat[1], 8'h55);
    chk("d_next_gap", tr_cyc[1] - er_cyc, 1);
    chk("d_first_ack_own", ak_own[0], 2);
    chk("d_retry_owner", tr_own[2], 1);

    // tx_done coincident with expiry
    do_reset();
    u_delay = TO - 1;
    push(0, 8'h81, 1'b1);
    repeat (115) @(negedge clk);
    chk("e_nack", n_ak, 1);
    chk("e_nerr", n_er, 0);
    chk("e_ack_delay", ak_cyc[0] - tr_cyc[0], 100);

    // Reset during WAIT_DONE, then a stray tx_done while idle
    do_reset();
    u_delay = 30;
    push(1, 8'h92, 1'b1);
    b = 0;
    while (trmt !== 1'b1 && b < 10) begin
      @(negedge clk);
      b++;
    end
    chk("f_trmt_seen", trmt, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("f_trmt", trmt, 0);
    chk("f_ack", ack, 0);
    chk("f_gnt", gnt, 0);
    chk("f_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    inj = 1;
    repeat (40) @(negedge clk);
    chk("f_nack", n_ak, 0);
    chk("f_nerr", n_er, 0);
    chk("f_ntrmt", n_tr, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
